sev_seg_scan_decoder: RTL

//  Receive end of the 4-digit multiplexed seven-segment bus driven by the digital clock.

---
 rtl/sev_seg_pkg.sv | 51 +++++
 rtl/sev_seg_scan_decoder_if.sv | 12 +
 rtl/sev_seg_scan_decoder_seg7_to_bcd.sv | 31 +++
 rtl/sev_seg_scan_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the seven-segment display path.
// The encoder (clock display driver) and this scan decoder import the same
// package, so glyph encodings and anode select codes are defined only here.
//  - GLYPH_0..GLYPH_9 : active-low cathode patterns, bit [6]=a .. bit [0]=g
//  - SEL_*            : active-low anode select codes for the four digits
//  - settle_state_e   : settle FSM states of the scan decoder
//  - decode_select    : maps a select code to a digit index (0=s2 .. 3=m1)
package sev_seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;

  localparam logic [3:0] SEL_S2    = 4'b1110;
  localparam logic [3:0] SEL_S1    = 4'b1101;
  localparam logic [3:0] SEL_M2    = 4'b1011;
  localparam logic [3:0] SEL_M1    = 4'b0111;
  localparam logic [3:0] SEL_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_SAMPLED  = 2'd2
  } settle_state_e;

  typedef struct packed {
    logic       legal;  // exactly one anode low
    logic [1:0] idx;    // 0=s2, 1=s1, 2=m2, 3=m1
  } sel_info_t;

  function automatic sel_info_t decode_select(input logic [3:0] sel);
    sel_info_t info;
    info = '{legal: 1'b0, idx: 2'd0};
    case (sel)
      SEL_S2:  info = '{legal: 1'b1, idx: 2'd0};
      SEL_S1:  info = '{legal: 1'b1, idx: 2'd1};
      SEL_M2:  info = '{legal: 1'b1, idx: 2'd2};
      SEL_M1:  info = '{legal: 1'b1, idx: 2'd3};
      default: info = '{legal: 1'b0, idx: 2'd0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sev_seg_scan_decoder_if.sv
// Multiplexed seven-segment bus as seen on the display pins.
//  digit_select : 4-bit active-low anode select
//  segments     : 7-bit active-low cathodes, [6]=a .. [0]=g
// The display driver uses the master modport; the scan decoder listens on
// the slave modport.
interface sev_seg_scan_decoder_if;
  logic [3:0] digit_select;
  logic [6:0] segments;

  modport master (output digit_select, output segments);
  modport slave  (input  digit_select, input  segments);
endinterface

// File: rtl/sev_seg_scan_decoder_seg7_to_bcd.sv
// Combinational glyph decoder.
//  glyph : 7-bit active-low pattern, [6]=a .. [0]=g
//  bcd   : decoded digit 0-9 (0 when not valid)
//  valid : 1 when glyph is one of the ten digit patterns
module seg7_to_bcd
  import sev_seg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = 4'd0;
    valid = 1'b1;
    case (glyph)
      GLYPH_0: bcd = 4'd0;
      GLYPH_1: bcd = 4'd1;
      GLYPH_2: bcd = 4'd2;
      GLYPH_3: bcd = 4'd3;
      GLYPH_4: bcd = 4'd4;
      GLYPH_5: bcd = 4'd5;
      GLYPH_6: bcd = 4'd6;
      GLYPH_7: bcd = 4'd7;
      GLYPH_8: bcd = 4'd8;
      GLYPH_9: bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_decoder.sv
// Receive side of the 4-digit multiplexed seven-segment bus.
// Waits for each digit slot to settle, decodes the glyph to BCD and assembles
// the four digits into MM:SS. Flags malformed samples and a stalled scan.
// Ports:
//  clk, reset    : clock and synchronous active-high reset
//  bus           : digit_select / segments (slave modport)
//  m1, m2, s1, s2: BCD digits, updated one cycle after each good sample
//  frame_valid   : 1-cycle pulse once all four digits have been captured
//  time_changed  : with frame_valid, frame differs from the previous one
//  seg_error     : 1-cycle pulse on a bad glyph or a multi-low select
//  scan_lost     : level, no select change for TIMEOUT_CYCLES cycles
module sev_seg_scan_decoder
  import sev_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  sev_seg_scan_decoder_if.slave   bus,
  output logic [3:0]              m1,
  output logic [3:0]              m2,
  output logic [3:0]              s1,
  output logic [3:0]              s2,
  output logic                    frame_valid,
  output logic                    time_changed,
  output logic                    seg_error,
  output logic                    scan_lost
);

  localparam logic [7:0] SETTLE_W = 8'(SETTLE_CYCLES);
  localparam int         TO_BITS  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_BITS-1:0] TO_MAX = TO_BITS'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------- inputs
  logic [3:0] sel_in;
  logic [6:0] seg_in;

  if (SYNC_STAGES == 0) begin : g_direct
    assign sel_in = bus.digit_select;
    assign seg_in = bus.segments;
  end else begin : g_sync
    // Stage 0 sits at the low end of each pipe vector; the last stage feeds
    // the decoder. Reset to "all segments off, no digit selected".
    logic [SYNC_STAGES*4-1:0] sel_pipe_q, sel_pipe_d;
    logic [SYNC_STAGES*7-1:0] seg_pipe_q, seg_pipe_d;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign sel_pipe_d[3:0] = bus.digit_select;
        assign seg_pipe_d[6:0] = bus.segments;
      end else begin : g_tail
        assign sel_pipe_d[gi*4 +: 4] = sel_pipe_q[(gi-1)*4 +: 4];
        assign seg_pipe_d[gi*7 +: 7] = seg_pipe_q[(gi-1)*7 +: 7];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sel_pipe_q <= '1;
        seg_pipe_q <= '1;
      end else begin
        sel_pipe_q <= sel_pipe_d;
        seg_pipe_q <= seg_pipe_d;
      end
    end

    assign sel_in = sel_pipe_q[(SYNC_STAGES-1)*4 +: 4];
    assign seg_in = seg_pipe_q[(SYNC_STAGES-1)*7 +: 7];
  end

  // ------------------------------------------------------------- decoding
  logic [3:0] glyph_bcd;
  logic       glyph_ok;
  sel_info_t  sel_info;

  seg7_to_bcd u_seg7_to_bcd (
    .glyph (seg_in),
    .bcd   (glyph_bcd),
    .valid (glyph_ok)
  );

  assign sel_info = decode_select(sel_in);

  // ----------------------------------------------------------------- state
  settle_state_e       state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          prev_sel_q, prev_sel_d;
  logic [6:0]          prev_seg_q, prev_seg_d;
  logic [3:0][3:0]     digits_q, digits_d;      // [0]=s2 .. [3]=m1
  logic [3:0][3:0]     last_frame_q, last_frame_d;
  logic                first_frame_q, first_frame_d;
  logic [3:0]          mask_q, mask_d;
  logic [TO_BITS-1:0]  to_cnt_q, to_cnt_d;
  logic                frame_valid_q, frame_valid_d;
  logic                time_changed_q, time_changed_d;
  logic                seg_error_q, seg_error_d;
  logic                scan_lost_q, scan_lost_d;

  logic       sel_chg;
  logic       pair_chg;
  logic       sample;
  logic [3:0] mask_set;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    digits_d       = digits_q;
    last_frame_d   = last_frame_q;
    first_frame_d  = first_frame_q;
    mask_d         = mask_q;
    frame_valid_d  = 1'b0;
    time_changed_d = 1'b0;
    seg_error_d    = 1'b0;
    mask_set       = mask_q;
    sample         = 1'b0;

    sel_chg    = (sel_in != prev_sel_q);
    pair_chg   = sel_chg || (seg_in != prev_seg_q);
    prev_sel_d = sel_in;
    prev_seg_d = seg_in;

    // The cycle a new select first appears counts as stable cycle 1, so a
    // settle length of 1 samples in that very cycle.
    case (state_q)
      ST_IDLE, ST_SAMPLED: begin
        if (sel_chg) begin
          state_d = ST_SETTLING;
          cnt_d   = 8'd1;
        end
      end
      ST_SETTLING: begin
        cnt_d = pair_chg ? 8'd1 : cnt_q + 8'd1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (state_d == ST_SETTLING && cnt_d == SETTLE_W) begin
      sample  = 1'b1;
      state_d = ST_SAMPLED;
    end

    // A blank select (all anodes off) is a legal gap in the scan: ignore it.
    if (sample && sel_in != SEL_BLANK) begin
      if (!sel_info.legal || !glyph_ok) begin
        seg_error_d = 1'b1;
      end else begin
        digits_d[sel_info.idx] = glyph_bcd;
        mask_set = mask_q | (4'b0001 << sel_info.idx);
        if (&mask_set) begin
          frame_valid_d  = 1'b1;
          time_changed_d = first_frame_q || (digits_d != last_frame_q);
          last_frame_d   = digits_d;
          first_frame_d  = 1'b0;
          mask_d         = 4'b0000;
        end else begin
          mask_d = mask_set;
        end
      end
    end

    // Stall watchdog: restarts on any select edge, sticks at the limit.
    if (sel_chg) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TO_BITS'(1);
    end
    scan_lost_d = (to_cnt_d == TO_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      prev_sel_q     <= SEL_BLANK;
      prev_seg_q     <= 7'h7F;
      digits_q       <= '0;
      last_frame_q   <= '0;
      first_frame_q  <= 1'b1;
      mask_q         <= 4'b0000;
      to_cnt_q       <= '0;
      frame_valid_q  <= 1'b0;
      time_changed_q <= 1'b0;
      seg_error_q    <= 1'b0;
      scan_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_sel_q     <= prev_sel_d;
      prev_seg_q     <= prev_seg_d;
      digits_q       <= digits_d;
      last_frame_q   <= last_frame_d;
      first_frame_q  <= first_frame_d;
      mask_q         <= mask_d;
      to_cnt_q       <= to_cnt_d;
      frame_valid_q  <= frame_valid_d;
      time_changed_q <= time_changed_d;
      seg_error_q    <= seg_error_d;
      scan_lost_q    <= scan_lost_d;
    end
  end

  assign s2           = digits_q[0];
  assign s1           = digits_q[1];
  assign m2           = digits_q[2];
  assign m1           = digits_q[3];
  assign frame_valid  = frame_valid_q;
  assign time_changed = time_changed_q;
  assign seg_error    = seg_error_q;
  assign scan_lost    = scan_lost_q;

endmodule
